// File: rtl/store_write_buffer_if.sv
// Store write buffer bus bundle: committed-store input, memory drain port,
// load-forwarding lookup and occupancy status.
//   master : store queue / memory / load unit side (drives in_*, mem_ack, ld_addr)
//   slave  : the write buffer (drives status, mem_* request, ld_hit/ld_data)
interface store_write_buffer_if #(
    parameter int unsigned WB_DEPTH = 4,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32
);
    localparam int unsigned CNT_W = $clog2(WB_DEPTH) + 1;

    // Committed stores from the store queue
    logic              in_valid;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;

    // Occupancy / status
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              overflow_err;

    // Memory write port
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ack;

    // Load forwarding lookup
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_hit;
    logic [DATA_W-1:0] ld_data;

    modport master (
        output in_valid, in_addr, in_data, mem_ack, ld_addr,
        input  full, empty, count, overflow_err,
        input  mem_req, mem_addr, mem_data, ld_hit, ld_data
    );

    modport slave (
        input  in_valid, in_addr, in_data, mem_ack, ld_addr,
        output full, empty, count, overflow_err,
        output mem_req, mem_addr, mem_data, ld_hit, ld_data
    );
endinterface

// File: rtl/store_write_buffer.sv
// Store write buffer: circular FIFO of committed stores, drained to memory one
// request at a time, with youngest-match store-to-load forwarding.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - store_write_buffer_if.slave (in_*, status, mem_*, ld_*)
module store_write_buffer #(
    parameter int unsigned WB_DEPTH = 4,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    store_write_buffer_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(WB_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t            state;

    logic [ADDR_W-1:0] addr_q [WB_DEPTH];
    logic [DATA_W-1:0] data_q [WB_DEPTH];
    logic [WB_DEPTH-1:0] valid_q;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;

    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_data_q;

    logic              full_c;
    logic              empty_c;
    logic              push_c;
    logic              pop_c;

    logic              ld_hit_c;
    logic [DATA_W-1:0] ld_data_c;
    logic [PTR_W-1:0]  fwd_idx;

    assign full_c  = (count_q == CNT_W'(WB_DEPTH));
    assign empty_c = (count_q == '0);
    // A store arriving while full is dropped even if the head pops this edge.
    assign push_c  = bus.in_valid && !full_c;
    assign pop_c   = (state == REQ) && bus.mem_ack;

    // Entry payload storage; only the valid bits need reset.
    always_ff @(posedge clk) begin
        if (push_c) begin
            addr_q[tail] <= bus.in_addr;
            data_q[tail] <= bus.in_data;
        end
    end

    // Pointers, occupancy, valid bits and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head       <= '0;
            tail       <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_c) begin
                tail          <= tail + PTR_W'(1);
                valid_q[tail] <= 1'b1;
            end
            // Head never equals tail here when both happen: push needs !full, pop needs count>0.
            if (pop_c) begin
                head          <= head + PTR_W'(1);
                valid_q[head] <= 1'b0;
            end
            if (push_c && !pop_c) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop_c && !push_c) begin
                count_q <= count_q - CNT_W'(1);
            end
            if (bus.in_valid && full_c) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Drain FSM: latch head into the request registers, hold until acked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty_c) begin
                        state      <= REQ;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= addr_q[head];
                        mem_data_q <= data_q[head];
                    end
                end
                REQ: begin
                    if (bus.mem_ack) begin
                        state     <= IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Forwarding: walk entries oldest to youngest so the youngest match wins.
    always_comb begin
        ld_hit_c  = 1'b0;
        ld_data_c = '0;
        fwd_idx   = head;
        for (int k = 0; k < WB_DEPTH; k++) begin
            fwd_idx = head + PTR_W'(k);
            if (valid_q[fwd_idx] && (addr_q[fwd_idx] == bus.ld_addr)) begin
                ld_hit_c  = 1'b1;
                ld_data_c = data_q[fwd_idx];
            end
        end
    end

    assign bus.full         = full_c;
    assign bus.empty        = empty_c;
    assign bus.count        = count_q;
    assign bus.overflow_err = overflow_q;
    assign bus.mem_req      = mem_req_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_data     = mem_data_q;
    assign bus.ld_hit       = ld_hit_c;
    assign bus.ld_data      = ld_data_c;
endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer: drain handshake, overflow, ordering,
// forwarding priority, push/pop collisions, request stability and reset abort.
module tb_store_write_buffer;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    store_write_buffer_if #(.WB_DEPTH(4), .ADDR_W(32), .DATA_W(32)) bus ();

    store_write_buffer #(.WB_DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        bus.in_valid = 1'b1;
        bus.in_addr  = a;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Wait (bounded) for a request, check its payload, ack it for one edge.
    task automatic drain_one(input string tag, input logic [31:0] ea, input logic [31:0] ed);
        int waited = 0;
        while (!bus.mem_req && waited < 8) begin
            tick();
            waited++;
        end
        if (!bus.mem_req) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s_timeout: observed mem_req=0 expected mem_req=1", tag);
        end else begin
            chk({tag, "_addr"}, bus.mem_addr, ea);
            chk({tag, "_data"}, bus.mem_data, ed);
            bus.mem_ack = 1'b1;
            tick();
            bus.mem_ack = 1'b0;
            chk({tag, "_req_low"}, 32'(bus.mem_req), 32'd0);
        end
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        bus.in_valid = 1'b0;
        bus.in_addr  = '0;
        bus.in_data  = '0;
        bus.mem_ack  = 1'b0;
        bus.ld_addr  = '0;
        rst_n        = 1'b1;
        #1 rst_n = 1'b0;
        #1;

        // Reset state
        chk("rst_empty",    32'(bus.empty),        32'd1);
        chk("rst_full",     32'(bus.full),         32'd0);
        chk("rst_count",    32'(bus.count),        32'd0);
        chk("rst_ovf",      32'(bus.overflow_err), 32'd0);
        chk("rst_req",      32'(bus.mem_req),      32'd0);
        chk("rst_addr",     bus.mem_addr,          32'd0);
        chk("rst_data",     bus.mem_data,          32'd0);
        chk("rst_ld_hit",   32'(bus.ld_hit),       32'd0);
        chk("rst_ld_data",  bus.ld_data,           32'd0);

        // Single store, push on first edge after release, ack on first request
        #10;
        rst_n        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_addr  = 32'h100;
        bus.in_data  = 32'hAA;
        tick();
        bus.in_valid = 1'b0;
        chk("t1_count",     32'(bus.count),   32'd1);
        chk("t1_req_early", 32'(bus.mem_req), 32'd0);
        tick();
        chk("t1_req",       32'(bus.mem_req), 32'd1);
        chk("t1_addr",      bus.mem_addr,     32'h100);
        chk("t1_data",      bus.mem_data,     32'hAA);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        chk("t1_req_fall",  32'(bus.mem_req), 32'd0);
        chk("t1_empty",     32'(bus.empty),   32'd1);

        // Fill to four, fifth dropped, drain in order
        push(32'h0, 32'hD0);
        push(32'h4, 32'hD1);
        push(32'h8, 32'hD2);
        push(32'hC, 32'hD3);
        chk("t2_full",      32'(bus.full),         32'd1);
        chk("t2_count",     32'(bus.count),        32'd4);
        push(32'h10, 32'hD4);
        chk("t2_ovf",       32'(bus.overflow_err), 32'd1);
        chk("t2_count_ovf", 32'(bus.count),        32'd4);
        bus.ld_addr = 32'h10;
        #1;
        chk("t2_drop_fwd",  32'(bus.ld_hit),       32'd0);
        drain_one("t2_d0", 32'h0, 32'hD0);
        drain_one("t2_d1", 32'h4, 32'hD1);
        drain_one("t2_d2", 32'h8, 32'hD2);
        drain_one("t2_d3", 32'hC, 32'hD3);
        chk("t2_empty",     32'(bus.empty),        32'd1);

        // Push while full with pop on the same edge, then push+pop at count 2
        push(32'h20, 32'h21);
        push(32'h24, 32'h25);
        push(32'h28, 32'h29);
        push(32'h2C, 32'h2D);
        chk("t3_full",      32'(bus.full),     32'd1);
        chk("t3_head",      bus.mem_addr,      32'h20);
        bus.mem_ack  = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_addr  = 32'h50;
        bus.in_data  = 32'h55;
        tick();
        bus.mem_ack  = 1'b0;
        bus.in_valid = 1'b0;
        chk("t3_count3",    32'(bus.count),    32'd3);
        chk("t3_notfull",   32'(bus.full),     32'd0);
        tick();
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        chk("t3_count2",    32'(bus.count),    32'd2);
        tick();
        chk("t3_req28",     bus.mem_addr,      32'h28);
        bus.mem_ack  = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_addr  = 32'h60;
        bus.in_data  = 32'h66;
        tick();
        bus.mem_ack  = 1'b0;
        bus.in_valid = 1'b0;
        chk("t3_count_hold", 32'(bus.count),   32'd2);
        bus.ld_addr = 32'h50;
        #1;
        chk("t3_drop50",    32'(bus.ld_hit),   32'd0);
        bus.ld_addr = 32'h60;
        #1;
        chk("t3_fwd60_hit", 32'(bus.ld_hit),   32'd1);
        chk("t3_fwd60_data", bus.ld_data,      32'h66);
        drain_one("t3_d2c", 32'h2C, 32'h2D);
        drain_one("t3_d60", 32'h60, 32'h66);

        // Youngest match wins; no forwarding of the store being pushed
        push(32'h40, 32'h11);
        push(32'h40, 32'h22);
        bus.ld_addr = 32'h40;
        #1;
        chk("t4_hit",       32'(bus.ld_hit),   32'd1);
        chk("t4_data",      bus.ld_data,       32'h22);
        bus.ld_addr = 32'h44;
        #1;
        chk("t4_miss_hit",  32'(bus.ld_hit),   32'd0);
        chk("t4_miss_data", bus.ld_data,       32'd0);
        bus.in_valid = 1'b1;
        bus.in_addr  = 32'h44;
        bus.in_data  = 32'h33;
        #1;
        chk("t4_no_bypass", 32'(bus.ld_hit),   32'd0);
        bus.in_valid = 1'b0;

        // Request held stable without ack; in-flight head stays forwardable
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        tick();
        bus.ld_addr = 32'h40;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_req",     32'(bus.mem_req), 32'd1);
            chk("t5_addr",    bus.mem_addr,     32'h40);
            chk("t5_data",    bus.mem_data,     32'h22);
            chk("t5_fwd_hit", 32'(bus.ld_hit),  32'd1);
            chk("t5_fwd_dat", bus.ld_data,      32'h22);
        end
        drain_one("t5_drain", 32'h40, 32'h22);
        chk("t5_empty",     32'(bus.empty),     32'd1);

        // Reset asserted mid-request
        push(32'h80, 32'h88);
        tick();
        chk("t6_req",       32'(bus.mem_req),      32'd1);
        chk("t6_ovf_sticky", 32'(bus.overflow_err), 32'd1);
        bus.ld_addr = 32'h80;
        #3 rst_n = 1'b0;
        #1;
        chk("t6_req_rst",   32'(bus.mem_req),      32'd0);
        chk("t6_count_rst", 32'(bus.count),        32'd0);
        chk("t6_empty_rst", 32'(bus.empty),        32'd1);
        chk("t6_addr_rst",  bus.mem_addr,          32'd0);
        chk("t6_fwd_rst",   32'(bus.ld_hit),       32'd0);
        chk("t6_ovf_rst",   32'(bus.overflow_err), 32'd0);
        #2 rst_n = 1'b1;
        bus.mem_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t6_no_replay", 32'(bus.mem_req), 32'd0);
            chk("t6_count_idle", 32'(bus.count),  32'd0);
        end
        bus.mem_ack = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
